xinput_debounce: RTL

//  Conditions the raw board inputs Btn2, Btn3 and Sw[7:0] before they reach the

---
 rtl/xinput_debounce.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/xinput_debounce.sv
// Board input conditioning: 2-FF synchronisers, hold-time debouncers, sticky
// press flags and a press counter, all exposed to xctrl through a 4-entry bus.

module xinput_debounce_chan #(
  parameter int W          = 1,
  parameter int DEB_W      = 20,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic [W-1:0] stable_nxt_o
);

  localparam logic [DEB_W-1:0] TC = DEB_W'(DEB_CYCLES - 1);

  logic [W-1:0]     sync1_q;
  logic [W-1:0]     sync2_q;
  logic [W-1:0]     prev_q;
  logic [W-1:0]     stable_q;
  logic [W-1:0]     stable_d;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;
  logic [DEB_W-1:0] cnt_base;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // any change of the synced value (bounce or a different vector) starts a fresh hold
    cnt_base = (sync2_q != prev_q) ? '0 : cnt_q;
    if (sync2_q != stable_q) begin
      if (cnt_base == TC) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_base + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_nxt_o = stable_d;

endmodule

module xinput_debounce #(
  parameter int DATA_W     = 32,
  parameter int DEB_W      = 20,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn2_raw,
  input  logic              btn3_raw,
  input  logic [7:0]        sw_raw,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              btn2_level,
  output logic              btn3_level,
  output logic [7:0]        sw_stable,
  output logic              evt_any
);

  logic       btn2_nxt;
  logic       btn3_nxt;
  logic [7:0] sw_nxt;
  logic [1:0] rise;
  logic [1:0] clr;
  logic       wr;
  logic [1:0] evt_q;
  logic [1:0] evt_d;
  logic [7:0] press_cnt_q;
  logic [7:0] press_cnt_d;
  logic [DATA_W-1:0] rdata;
  logic       unused_data_in;
  logic [7:0] unused_sw_nxt;

  xinput_debounce_chan #(
    .W          (1),
    .DEB_W      (DEB_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn2 (
    .clk          (clk),
    .rst          (rst),
    .raw_i        (btn2_raw),
    .stable_o     (btn2_level),
    .stable_nxt_o (btn2_nxt)
  );

  xinput_debounce_chan #(
    .W          (1),
    .DEB_W      (DEB_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn3 (
    .clk          (clk),
    .rst          (rst),
    .raw_i        (btn3_raw),
    .stable_o     (btn3_level),
    .stable_nxt_o (btn3_nxt)
  );

  xinput_debounce_chan #(
    .W          (8),
    .DEB_W      (DEB_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw (
    .clk          (clk),
    .rst          (rst),
    .raw_i        (sw_raw),
    .stable_o     (sw_stable),
    .stable_nxt_o (sw_nxt)
  );

  assign unused_sw_nxt  = sw_nxt;
  assign unused_data_in = ^data_in[DATA_W-1:8];

  always_comb begin
    wr   = sel & we;
    rise = {btn3_nxt & ~btn3_level, btn2_nxt & ~btn2_level};
    clr  = (wr && addr == 2'd2) ? data_in[1:0] : 2'b00;
    // a press landing on the same edge as its clear keeps the flag
    evt_d = (evt_q & ~clr) | rise;
    if (wr && addr == 2'd3) begin
      press_cnt_d = data_in[7:0];
    end else begin
      press_cnt_d = press_cnt_q + {7'b0, rise[0]} + {7'b0, rise[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q       <= '0;
      press_cnt_q <= '0;
    end else begin
      evt_q       <= evt_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign evt_any = |evt_q;

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata[1:0] = {btn3_level, btn2_level};
      2'd1:    rdata[7:0] = sw_stable;
      2'd2:    rdata[1:0] = evt_q;
      default: rdata[7:0] = press_cnt_q;
    endcase
    data_out = sel ? rdata : '0;
  end

endmodule
